// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the run controller: instruction field layout, instruction
// classes, the boot JMP-to-0 word and the sequencer state encoding.
package cpu_ctrl_pkg;

  localparam int unsigned InsW = 21;

  localparam int unsigned ImmLsb     = 0;
  localparam int unsigned ImmW       = 8;
  localparam int unsigned BmuxLsb    = 8;
  localparam int unsigned BmuxW      = 3;
  localparam int unsigned AmuxLsb    = 11;
  localparam int unsigned AmuxW      = 3;
  localparam int unsigned OpcodeLsb  = 14;
  localparam int unsigned OpcodeW    = 4;
  // Jumps reuse the opcode field as their target/condition select.
  localparam int unsigned TgtLsb     = 14;
  localparam int unsigned TgtW       = 4;
  localparam int unsigned IrLsb      = 18;
  localparam int unsigned InstypeLsb = 19;
  localparam int unsigned InstypeW   = 2;

  typedef enum logic [1:0] {
    InsJmp  = 2'd0,
    InsMov  = 2'd1,
    InsCmp  = 2'd2,
    InsMath = 2'd3
  } ins_type_e;

  localparam logic [InsW-1:0] Jmp0 = {InsJmp, 1'b0, 4'b0111, 3'b000, 3'b000, 8'hFF};

  typedef enum logic [2:0] {
    StBoot     = 3'd0,
    StBootTick = 3'd1,
    StHalt     = 3'd2,
    StRun      = 3'd3,
    StStep     = 3'd4
  } run_state_e;

endpackage

// File: rtl/cpu_run_controller_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse on the
// rising edge of the synchronized value.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer producing a one-cycle CPU clock-enable and the boot JMP mux.
// Define CPU_CTRL_BREAKPOINT_EN to build the address breakpoint; otherwise it is inert.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV     = 12500000,
  parameter int unsigned PRESC_W = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RESET_REQ,
  input  logic             RUN_SW,
  input  logic             STEP_BTN,
  input  logic [7:0]       ADDR,
  input  logic [InsW-1:0]  ROM_INS,
  input  logic             BP_EN,
  input  logic [7:0]       BP_ADDR,
  output logic [InsW-1:0]  INS_PORT,
  output logic             CPU_TICK,
  output logic [2:0]       STATE,
  output logic             BP_HIT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(DIV - 1);

  logic reset_req_s, run_s, run_rise, step_rise;
  logic unused_reset_req_rise, unused_step_level;

  sync_edge u_sync_reset_req (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (RESET_REQ),
    .sync_o (reset_req_s),
    .rise_o (unused_reset_req_rise)
  );

  sync_edge u_sync_run (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (RUN_SW),
    .sync_o (run_s),
    .rise_o (run_rise)
  );

  sync_edge u_sync_step (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (STEP_BTN),
    .sync_o (unused_step_level),
    .rise_o (step_rise)
  );

  run_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cpu_tick;
  logic               bp_hit;

  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    cpu_tick = 1'b0;
    unique case (state_q)
      StBoot: begin
        if (!reset_req_s) state_d = StBootTick;
      end
      StBootTick: begin
        cpu_tick = 1'b1;
        state_d  = run_s ? StRun : StHalt;
      end
      StRun: begin
        if (!run_s) begin
          state_d = StHalt;
        end else if (presc_q == PrescLast) begin
          if (bp_hit) state_d = StHalt;
          else        cpu_tick = 1'b1;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      StHalt: begin
        if (run_rise)       state_d = StRun;
        else if (step_rise) state_d = StStep;
      end
      StStep: begin
        cpu_tick = 1'b1;
        state_d  = StHalt;
      end
      default: state_d = StBoot;
    endcase
    // User reset wins over every transition; a tick already decoded this cycle stands.
    if (reset_req_s) begin
      state_d = StBoot;
      presc_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StBoot) cnt_d = '0;
    else if (cpu_tick)     cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= StBoot;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CPU_CTRL_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;
  logic bp_flag_q, bp_flag_d;
  logic arm_skip, bp_stop;

  assign bp_hit   = BP_EN && (ADDR == BP_ADDR) && !bp_skip_q;
  assign arm_skip = ((state_q == StHalt) && run_rise) || (state_q == StStep);
  assign bp_stop  = (state_q == StRun) && run_s && (presc_q == PrescLast) && bp_hit;

  // The skip lets a resumed or stepped CPU execute the breakpointed instruction once.
  always_comb begin
    bp_skip_d = bp_skip_q;
    if (cpu_tick) bp_skip_d = 1'b0;
    if (arm_skip) bp_skip_d = 1'b1;
    bp_flag_d = bp_flag_q;
    if (arm_skip) bp_flag_d = 1'b0;
    if (bp_stop)  bp_flag_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bp_skip_q <= 1'b0;
      bp_flag_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
      bp_flag_q <= bp_flag_d;
    end
  end

  assign BP_HIT = bp_flag_q;
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{BP_EN, BP_ADDR, ADDR};
  assign bp_hit = 1'b0;
  assign BP_HIT = 1'b0;
`endif

  assign INS_PORT  = ((state_q == StBoot) || (state_q == StBootTick)) ? Jmp0 : ROM_INS;
  assign CPU_TICK  = cpu_tick;
  assign STATE     = state_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller with DIV=4 and an 8-bit instruction counter.
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  localparam int unsigned Div  = 4;
  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst_n, reset_req, run_sw, step_btn, bp_en;
  logic [7:0]      addr, bp_addr;
  logic [20:0]     rom_ins, ins_port;
  logic            cpu_tick, bp_hit;
  logic [2:0]      state;
  logic [CntW-1:0] instr_cnt;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .DIV     (Div),
    .PRESC_W (24),
    .CNT_W   (CntW)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .RESET_REQ (reset_req),
    .RUN_SW    (run_sw),
    .STEP_BTN  (step_btn),
    .ADDR      (addr),
    .ROM_INS   (rom_ins),
    .BP_EN     (bp_en),
    .BP_ADDR   (bp_addr),
    .INS_PORT  (ins_port),
    .CPU_TICK  (cpu_tick),
    .STATE     (state),
    .BP_HIT    (bp_hit),
    .INSTR_CNT (instr_cnt)
  );

  function automatic logic [20:0] rom(input logic [7:0] a);
    return {13'h1A55, a};
  endfunction

  // Minimal CPU: JMP0 goes to 0, anything else falls through to the next address.
  assign rom_ins = rom(addr);
  always @(posedge clk) begin
    if (!rst_n)        addr <= 8'd0;
    else if (cpu_tick) addr <= (ins_port == Jmp0) ? 8'd0 : addr + 8'd1;
  end

  typedef struct packed {
    logic [2:0]      st;
    logic [20:0]     ins;
    logic [CntW-1:0] cnt;
  } tick_t;

  tick_t           exp_q[$];
  tick_t           mon_exp, mon_act;
  int              checks = 0;
  int              passes = 0;
  logic [7:0]      exp_addr;
  logic [CntW-1:0] exp_cnt;
  logic            prev_tick = 1'b0;

  always @(negedge clk) begin
    if (cpu_tick) begin
      checks++;
      if (prev_tick) $display("FAIL tick_spacing: tick on consecutive cycles, required a gap");
      else passes++;
      checks++;
      mon_act.st  = state;
      mon_act.ins = ins_port;
      mon_act.cnt = instr_cnt;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_tick: state=%0d ins=0x%0h cnt=%0d, required no tick",
                 state, ins_port, instr_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp)
          $display("FAIL tick_seq: state=%0d ins=0x%0h cnt=%0d, required state=%0d ins=0x%0h cnt=%0d",
                   mon_act.st, mon_act.ins, mon_act.cnt, mon_exp.st, mon_exp.ins, mon_exp.cnt);
        else passes++;
      end
    end
    prev_tick = cpu_tick;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passes++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] st, input logic [20:0] ins);
    tick_t t;
    t.st  = st;
    t.ins = ins;
    t.cnt = exp_cnt;
    exp_q.push_back(t);
    exp_cnt++;
  endtask

  task automatic push_boot();
    exp_cnt = '0;
    push(StBootTick, Jmp0);
    exp_addr = 8'd0;
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      push(StRun, rom(exp_addr));
      exp_addr++;
    end
  endtask

  task automatic push_step();
    push(StStep, rom(exp_addr));
    exp_addr++;
  endtask

  task automatic drain(input int limit, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s: %0d ticks still pending after %0d cycles, required 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end else begin
      passes++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; reset_req = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 8'd0;
    exp_addr = 8'd0; exp_cnt = '0;

    // 1. reset, then a single boot tick into HALT
    cyc(2); sample();
    check("rst_state", 32'(state), 32'(StBoot));
    check("rst_ins", 32'(ins_port), 32'(Jmp0));
    check("rst_tick", 32'(cpu_tick), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    push_boot();
    rst_n = 1'b1;
    drain(10, "boot_tick");
    cyc(2); sample();
    check("boot_to_halt", 32'(state), 32'(StHalt));
    check("boot_cnt", 32'(instr_cnt), 32'd1);

    // 2. run for three ticks, then drop the switch right after a tick
    run_sw = 1'b1;
    push_run(3);
    drain(40, "run_ticks");
    run_sw = 1'b0;
    cyc(3); sample();
    check("run_drop_halt", 32'(state), 32'(StHalt));
    check("run_cnt", 32'(instr_cnt), 32'd4);
    cyc(8);

    // 3. a run edge landing in STEP is lost; the held level must not resume
    step_btn = 1'b1;
    cyc(1);
    run_sw = 1'b1;
    push_step();
    drain(20, "step_tick");
    cyc(10); sample();
    check("halt_run_level", 32'(state), 32'(StHalt));
    check("step_cnt", 32'(instr_cnt), 32'd5);
    step_btn = 1'b0;
    cyc(3);
    step_btn = 1'b1;
    push_step();
    cyc(3);
    step_btn = 1'b0;
    drain(20, "step2_tick");
    cyc(4); sample();
    check("step2_halt", 32'(state), 32'(StHalt));
    check("step2_cnt", 32'(instr_cnt), 32'd6);

    // 4. breakpoint at address 4, run switch already high across reset
    rst_n = 1'b0; bp_en = 1'b1; bp_addr = 8'd4;
    cyc(2);
    push_boot();
    rst_n = 1'b1;
`ifdef CPU_CTRL_BREAKPOINT_EN
    push_run(4);
    drain(60, "bp_run");
    cyc(8); sample();
    check("bp_halt_state", 32'(state), 32'(StHalt));
    check("bp_halt_addr", 32'(addr), 32'd4);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_halt_cnt", 32'(instr_cnt), 32'd5);
    run_sw = 1'b0;
    cyc(4); sample();
    check("bp_hold", 32'(state), 32'(StHalt));
    run_sw = 1'b1;
    push_run(2);
    drain(40, "bp_resume");
`else
    push_run(6);
    drain(60, "nobp_run");
`endif
    run_sw = 1'b0;
    cyc(3); sample();
    check("bp_end_halt", 32'(state), 32'(StHalt));
    check("bp_hit_clear", 32'(bp_hit), 32'd0);
    check("bp_end_cnt", 32'(instr_cnt), 32'd7);
    bp_en = 1'b0;

    // 5. user reset request in the middle of RUN
    run_sw = 1'b1;
    push_run(1);
    drain(30, "pre_req_run");
    reset_req = 1'b1;
    cyc(3); sample();
    check("req_boot", 32'(state), 32'(StBoot));
    cyc(3); sample();
    check("req_hold_boot", 32'(state), 32'(StBoot));
    check("req_cnt_clear", 32'(instr_cnt), 32'd0);
    check("req_ins", 32'(ins_port), 32'(Jmp0));
    push_boot();
    push_run(2);
    reset_req = 1'b0;
    drain(60, "req_release");
    sample();
    check("req_to_run", 32'(state), 32'(StRun));
    run_sw = 1'b0;
    cyc(3); sample();
    check("req_end_halt", 32'(state), 32'(StHalt));
    check("req_end_cnt", 32'(instr_cnt), 32'd3);

    // 6. run the counter up to all-ones, then one step wraps it
    run_sw = 1'b1;
    push_run(252);
    drain(1200, "long_run");
    run_sw = 1'b0;
    cyc(3); sample();
    check("cnt_full", 32'(instr_cnt), 32'hFF);
    step_btn = 1'b1;
    push_step();
    drain(20, "wrap_step");
    step_btn = 1'b0;
    cyc(2); sample();
    check("cnt_wrap", 32'(instr_cnt), 32'd0);
    check("wrap_halt", 32'(state), 32'(StHalt));
    cyc(6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
